// File: rtl/conv1_frame_sched_if.sv
// -----------------------------------------------------------------------------
// conv1_frame_sched_if
// Groups every non-clock signal of the layer-1 frame sequencer.
//   Controller handshake : start, abort -> ; <- busy, done, err
//   Pixel RAM read port  : img_rd_en, img_rd_addr -> ; <- img_rd_data
//   Layer-1 datapath     : lyr_rst, lyr_pixel, lyr_valid -> ;
//                          <- lyr_invalid, lyr_finish, lyr_out
//   Feature-map RAM write: fm_wr_en, fm_wr_addr, fm_wr_data ->
// master = the sequencer, slave = its surroundings (controller, RAMs, layer).
// -----------------------------------------------------------------------------
interface conv1_frame_sched_if #(
  parameter int PIX_BITS = 16,
  parameter int OUT_BITS = 32
);
  logic                  start;
  logic                  abort;
  logic                  busy;
  logic                  done;
  logic                  err;
  logic                  img_rd_en;
  logic [9:0]            img_rd_addr;
  logic [PIX_BITS-1:0]   img_rd_data;
  logic                  lyr_rst;
  logic [PIX_BITS-1:0]   lyr_pixel;
  logic                  lyr_valid;
  logic                  lyr_invalid;
  logic                  lyr_finish;
  logic [6*OUT_BITS-1:0] lyr_out;
  logic                  fm_wr_en;
  logic [9:0]            fm_wr_addr;
  logic [6*OUT_BITS-1:0] fm_wr_data;

  modport master (
    input  start, abort, img_rd_data, lyr_invalid, lyr_finish, lyr_out,
    output busy, done, err, img_rd_en, img_rd_addr, lyr_rst, lyr_pixel,
           lyr_valid, fm_wr_en, fm_wr_addr, fm_wr_data
  );

  modport slave (
    output start, abort, img_rd_data, lyr_invalid, lyr_finish, lyr_out,
    input  busy, done, err, img_rd_en, img_rd_addr, lyr_rst, lyr_pixel,
           lyr_valid, fm_wr_en, fm_wr_addr, fm_wr_data
  );
endinterface

// File: rtl/conv1_frame_sched.sv
// -----------------------------------------------------------------------------
// conv1_frame_sched
// Frame-level sequencer for convolution layer 1 (6 kernels, 5x5, 28x28 in,
// 24x24 out). On start it resets the layer for one cycle, streams the whole
// image from the pixel RAM into the layer, collects the layer's 6-channel
// results into the feature-map RAM, then pulses done (with err on timeout or
// a wrong number of results).
// Ports:
//   clk_global  : clock, rising edge
//   reset_layer : asynchronous active-high reset
//   bus         : conv1_frame_sched_if.master (handshake, pixel RAM, layer,
//                 feature-map RAM)
// -----------------------------------------------------------------------------
module conv1_frame_sched #(
  parameter int IMG_W    = 28,
  parameter int KER_W    = 5,
  parameter int PIX_BITS = 16,
  parameter int OUT_BITS = 32,
  parameter int TIMEOUT  = 4095
) (
  input  logic                clk_global,
  input  logic                reset_layer,
  conv1_frame_sched_if.master bus
);

  localparam int          FRAME     = IMG_W * IMG_W;
  localparam int          MAP_W     = IMG_W - KER_W + 1;
  localparam int          OUT_N     = MAP_W * MAP_W;
  localparam logic [9:0]  LAST_ADDR = 10'(FRAME - 1);
  localparam logic [9:0]  WR_FULL   = 10'(OUT_N);
  localparam logic [11:0] TMO_LAST  = 12'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_FEED,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t                state;
  logic                  busy_q;
  logic                  done_q;
  logic                  err_q;
  logic                  rd_en_q;
  logic [9:0]            rd_addr;
  logic                  valid_q;
  logic                  rst_q;
  logic [11:0]           tmo_cnt;
  logic                  flush;      // DRAIN's extra cycle after lyr_finish

  logic                  wr_en_q;
  logic [9:0]            wr_addr_q;
  logic [6*OUT_BITS-1:0] wr_data_q;
  logic [9:0]            wr_cnt;
  logic                  overflow;

  logic                  in_drain;
  logic                  tmo_exit;
  logic                  capture;
  logic [PIX_BITS-1:0]   pixel;

  // NOTE: every signal gets a value on every pass through always_comb, so no
  // path can leave one unassigned and infer a latch.
  always_comb begin
    in_drain = (state == S_DRAIN) && !flush;
    // lyr_finish wins over a coincident timeout.
    tmo_exit = in_drain && !bus.lyr_finish && (tmo_cnt == TMO_LAST);
    // No result is taken in the flush cycle or on the timeout edge, so the
    // last write always lands before DONE and err sees the final count.
    capture  = !bus.abort && !bus.lyr_invalid &&
               ((state == S_FEED) || (in_drain && !tmo_exit));
  end

  // Frame FSM with registered outputs.
  always_ff @(posedge clk_global or posedge reset_layer) begin
    if (reset_layer) begin
      state   <= S_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      rd_en_q <= 1'b0;
      rd_addr <= '0;
      valid_q <= 1'b0;
      rst_q   <= 1'b1;
      tmo_cnt <= '0;
      flush   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every register samples
      // the pre-edge value of every other register regardless of order.
      valid_q <= rd_en_q && !bus.abort;
      if (bus.abort) begin
        state   <= S_IDLE;
        busy_q  <= 1'b0;
        done_q  <= 1'b0;
        rd_en_q <= 1'b0;
        rd_addr <= '0;
        rst_q   <= 1'b1;
        flush   <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (bus.start) begin
              state  <= S_CLEAR;
              busy_q <= 1'b1;
              err_q  <= 1'b0;
            end
          end
          S_CLEAR: begin
            state   <= S_FEED;
            rd_en_q <= 1'b1;
            rd_addr <= '0;
            tmo_cnt <= '0;
            flush   <= 1'b0;
            rst_q   <= 1'b0;
          end
          S_FEED: begin
            if (rd_addr == LAST_ADDR) begin
              state   <= S_DRAIN;
              rd_en_q <= 1'b0;
            end else begin
              rd_addr <= rd_addr + 10'd1;
            end
          end
          S_DRAIN: begin
            if (flush) begin
              state  <= S_DONE;
              done_q <= 1'b1;
              err_q  <= overflow || (wr_cnt != WR_FULL);
              flush  <= 1'b0;
            end else if (bus.lyr_finish) begin
              flush <= 1'b1;
            end else if (tmo_exit) begin
              state  <= S_DONE;
              done_q <= 1'b1;
              err_q  <= 1'b1;
            end else begin
              tmo_cnt <= tmo_cnt + 12'd1;
            end
          end
          S_DONE: begin
            state  <= S_IDLE;
            done_q <= 1'b0;
            busy_q <= 1'b0;
            rst_q  <= 1'b1;
          end
          default: begin
            state   <= S_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            rd_en_q <= 1'b0;
            rst_q   <= 1'b1;
          end
        endcase
      end
    end
  end

  // Writeback: a result taken this cycle is written on the next one at the
  // current count; the count saturates at a full map and extras only flag.
  always_ff @(posedge clk_global or posedge reset_layer) begin
    if (reset_layer) begin
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      wr_cnt    <= '0;
      overflow  <= 1'b0;
    end else begin
      wr_en_q <= 1'b0;
      if (state == S_CLEAR) begin
        wr_cnt   <= '0;
        overflow <= 1'b0;
      end else if (capture) begin
        wr_data_q <= bus.lyr_out;
        wr_addr_q <= wr_cnt;
        if (wr_cnt == WR_FULL) begin
          overflow <= 1'b1;
        end else begin
          wr_en_q <= 1'b1;
          wr_cnt  <= wr_cnt + 10'd1;
        end
      end
    end
  end

  assign pixel = bus.img_rd_data;

  // abort must silence the strobes and hold the layer in reset in the very
  // cycle it is raised, ahead of the registers catching up on the next edge.
  assign bus.busy        = busy_q;
  assign bus.done        = done_q && !bus.abort;
  assign bus.err         = err_q;
  assign bus.img_rd_en   = rd_en_q && !bus.abort;
  assign bus.img_rd_addr = rd_addr;
  assign bus.lyr_rst     = rst_q || bus.abort;
  assign bus.lyr_pixel   = pixel;
  assign bus.lyr_valid   = valid_q && !bus.abort;
  assign bus.fm_wr_en    = wr_en_q && !bus.abort;
  assign bus.fm_wr_addr  = wr_addr_q;
  assign bus.fm_wr_data  = wr_data_q;

endmodule

// File: tb/tb_conv1_frame_sched.sv
// -----------------------------------------------------------------------------
// tb_conv1_frame_sched
// Drives conv1_frame_sched through whole frames with a random image and a
// random layer model: results with random gaps, a scoreboard of what must land
// in the feature-map RAM, and the expected done cycle / err flag derived from
// the frame timeline (1 CLEAR cycle, 784 FEED cycles, then DRAIN).
// Inputs are driven on the falling edge, outputs sampled 1 ns later.
// -----------------------------------------------------------------------------
module tb_conv1_frame_sched;

  localparam int FRAME   = 784;
  localparam int OUT_N   = 576;
  localparam int TIMEOUT = 4095;
  localparam int OW      = 192;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  conv1_frame_sched_if #(.PIX_BITS(16), .OUT_BITS(32)) bus ();

  conv1_frame_sched #(
    .IMG_W(28), .KER_W(5), .PIX_BITS(16), .OUT_BITS(32), .TIMEOUT(TIMEOUT)
  ) u_dut (
    .clk_global (clk),
    .reset_layer(rst),
    .bus        (bus)
  );

  int          checks = 0;
  int          errors = 0;
  logic [15:0] mem [FRAME];
  logic        last_err = 1'b0;

  task automatic check(input string tag, input logic [OW-1:0] obs,
                       input logic [OW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_idle();
    bus.start       = 1'b0;
    bus.abort       = 1'b0;
    bus.lyr_invalid = 1'b1;
    bus.lyr_finish  = 1'b0;
    bus.lyr_out     = '0;
    bus.img_rd_data = '0;
  endtask

  task automatic check_reset_values(input string name);
    check({name, ":busy"},    bus.busy, 0);
    check({name, ":done"},    bus.done, 0);
    check({name, ":err"},     bus.err, 0);
    check({name, ":rd_en"},   bus.img_rd_en, 0);
    check({name, ":rd_addr"}, bus.img_rd_addr, 0);
    check({name, ":valid"},   bus.lyr_valid, 0);
    check({name, ":wr_en"},   bus.fm_wr_en, 0);
    check({name, ":wr_addr"}, bus.fm_wr_addr, 0);
    check({name, ":lyr_rst"}, bus.lyr_rst, 1);
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) begin
      @(negedge clk);
      drive_idle();
      #1;
      check("idle:busy", bus.busy, 0);
      check("idle:done", bus.done, 0);
    end
  endtask

  // One frame. n_out results are offered by the layer model; fin selects
  // whether lyr_finish is raised fin_gap cycles after the last result.
  // abort_rel / reset_rel (frame-relative cycle, -1 = never) cut the frame.
  task automatic run_frame(input string name, input int n_out, input bit fin,
                           input int fin_gap, input int abort_rel,
                           input bit hold_start, input int reset_rel);
    logic [OW-1:0] exp_q[$];
    logic [OW-1:0] v;
    logic [15:0]   exp_pix;
    logic          p_en = 1'b0;
    logic [9:0]    p_addr = '0;
    int            reads = 0, beats = 0, emitted = 0, writes = 0;
    int            last_emit = -1, fin_rel = -1, exp_done;
    bit            feed_over = 1'b0, finished = 1'b0;
    bit            exp_err = !fin || (n_out != OUT_N);
    int            exp_writes = (n_out < OUT_N) ? n_out : OUT_N;

    @(negedge clk);
    drive_idle();
    bus.start = 1'b1;
    #1;
    check({name, ":idle_busy"}, bus.busy, 0);
    check({name, ":err_held"},  bus.err, last_err);
    check({name, ":idle_rst"},  bus.lyr_rst, 1);

    for (int rel = 1; rel < 6000 && !finished; rel++) begin
      @(negedge clk);
      drive_idle();
      bus.start = hold_start && (rel < 700);
      exp_pix = p_en ? mem[p_addr] : 16'($urandom);
      bus.img_rd_data = exp_pix;
      // Last result is held back until the image is fully fed.
      if (beats >= 20 && emitted < n_out && (emitted < n_out - 1 || feed_over)
          && $urandom_range(3) != 0) begin
        for (int k = 0; k < 6; k++) v[k*32 +: 32] = $urandom;
        bus.lyr_invalid = 1'b0;
        bus.lyr_out     = v;
        exp_q.push_back(v);
        emitted++;
        last_emit = rel;
      end
      if (fin && fin_rel < 0 && emitted == n_out && feed_over &&
          rel >= last_emit + fin_gap) begin
        bus.lyr_finish = 1'b1;
        fin_rel = rel;
      end
      if (rel == abort_rel) bus.abort = 1'b1;
      #1;
      check({name, ":pixel"}, bus.lyr_pixel, exp_pix);

      if (rel == abort_rel) begin
        check({name, ":abort_addr"},  bus.img_rd_addr, rel - 2);
        check({name, ":abort_rd_en"}, bus.img_rd_en, 0);
        check({name, ":abort_valid"}, bus.lyr_valid, 0);
        check({name, ":abort_wr_en"}, bus.fm_wr_en, 0);
        check({name, ":abort_rst"},   bus.lyr_rst, 1);
        check({name, ":abort_done"},  bus.done, 0);
        repeat (4) begin
          @(negedge clk);
          drive_idle();
          #1;
          check({name, ":post_abort_busy"},  bus.busy, 0);
          check({name, ":post_abort_done"},  bus.done, 0);
          check({name, ":post_abort_rst"},   bus.lyr_rst, 1);
          check({name, ":post_abort_rd_en"}, bus.img_rd_en, 0);
        end
        last_err = 1'b0;
        finished = 1'b1;
        continue;
      end

      exp_done = fin ? ((fin_rel < 0) ? -1 : fin_rel + 2) : 2 + FRAME + TIMEOUT;
      check({name, ":busy"},    bus.busy, 1);
      check({name, ":lyr_rst"}, bus.lyr_rst, rel == 1);
      if (rel == 1) check({name, ":clear_err"}, bus.err, 0);
      check({name, ":rd_en"},   bus.img_rd_en, (rel >= 2) && (rel < 2 + FRAME));
      check({name, ":valid"},   bus.lyr_valid, p_en);
      check({name, ":done"},    bus.done, rel == exp_done);
      if (bus.img_rd_en) begin
        check({name, ":rd_addr"}, bus.img_rd_addr, reads);
        reads++;
      end
      if (bus.lyr_valid) beats++;
      if (bus.fm_wr_en) begin
        check({name, ":wr_addr"}, bus.fm_wr_addr, writes);
        if (writes < exp_q.size())
          check({name, ":wr_data"}, bus.fm_wr_data, exp_q[writes]);
        writes++;
      end
      p_en   = bus.img_rd_en;
      p_addr = bus.img_rd_addr;
      if (reads == FRAME) feed_over = 1'b1;

      if (rel == reset_rel) begin
        #2;
        rst = 1'b1;
        #1;
        check_reset_values({name, ":async_rst"});
        @(negedge clk);
        drive_idle();
        rst = 1'b0;
        last_err = 1'b0;
        finished = 1'b1;
      end else if (rel == exp_done || bus.done) begin
        check({name, ":err"},    bus.err, exp_err);
        check({name, ":writes"}, writes, exp_writes);
        @(negedge clk);
        drive_idle();
        #1;
        check({name, ":after_busy"}, bus.busy, 0);
        check({name, ":after_done"}, bus.done, 0);
        check({name, ":after_err"},  bus.err, exp_err);
        check({name, ":after_rst"},  bus.lyr_rst, 1);
        last_err = exp_err;
        finished = 1'b1;
      end
    end
    check({name, ":completed"}, finished, 1);
  endtask

  initial begin
    for (int i = 0; i < FRAME; i++) mem[i] = 16'($urandom);
    rst = 1'b1;
    drive_idle();
    @(negedge clk);
    #1;
    check_reset_values("reset");
    @(negedge clk);
    rst = 1'b0;
    idle_cycles(3);

    // start and abort together in IDLE: abort wins.
    @(negedge clk);
    drive_idle();
    bus.start = 1'b1;
    bus.abort = 1'b1;
    #1;
    check("start_abort:rst", bus.lyr_rst, 1);
    idle_cycles(3);

    run_frame("nominal",     576, 1'b1, 0, -1,      1'b0, -1);
    idle_cycles(2);
    run_frame("hold_start",  576, 1'b1, 3, -1,      1'b1, -1);
    idle_cycles(2);
    run_frame("over580",     580, 1'b1, 1, -1,      1'b0, -1);
    idle_cycles(2);
    run_frame("under570",    570, 1'b1, 0, -1,      1'b0, -1);
    idle_cycles(2);
    run_frame("timeout",     576, 1'b0, 0, -1,      1'b0, -1);
    idle_cycles(2);
    run_frame("abort300",    576, 1'b1, 0, 2 + 300, 1'b0, -1);
    idle_cycles(2);
    run_frame("after_abort", 576, 1'b1, 2, -1,      1'b0, -1);
    idle_cycles(2);
    run_frame("reset_drain", 576, 1'b0, 0, -1,      1'b0, 900);
    idle_cycles(2);
    run_frame("post_reset",  576, 1'b1, 0, -1,      1'b0, -1);
    idle_cycles(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
